packet_sender_ece496: RTL and testbench
=======================================

PACKET_SENDER_ECE496 -- requirements
Module: packet_sender_ece496

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 4 (legal range 1-16), giving the number of payload bytes per packet after the header.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port mux_select  input  3  stream index from the stream switch.
REQ-005 SHALL have port select_ready  input  1  high while the switch grants stream mux_select; held until packet_sent.
REQ-006 SHALL have port stream_data  input  8  muxed FIFO read data, valid the cycle after a read strobe.
REQ-007 SHALL have port stream_empty  input  1  empty flag of the FIFO addressed by mux_select.
REQ-008 SHALL have port uart_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-009 SHALL have port fifo_rd  output  8  one-hot FIFO read strobes.
REQ-010 SHALL have port uart_data  output  8  byte to transmit.
REQ-011 SHALL have port uart_send  output  1  one-cycle load strobe to the UART.
REQ-012 SHALL have port ready_to_send  output  1  sender idle and UART ready.
REQ-013 SHALL have port packet_sent  output  1  one-cycle pulse; packet complete.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, RD, LAT, TX and DONE.
REQ-015 IDLE: ready_to_send SHALL equal uart_ready; when select_ready=1, latch sel<=mux_select, clear cnt, and go to HDR; otherwise stay in IDLE.
REQ-016 ready_to_send SHALL be 0 in every state other than IDLE.
REQ-017 HDR: when uart_ready=1, SHALL assert uart_send with uart_data={4'hA,1'b0,sel} and go to RD; otherwise hold.
REQ-018 RD: when stream_empty=0, SHALL assert fifo_rd[sel] (only that bit) for exactly one cycle and go to LAT; when stream_empty=1, SHALL hold in RD with fifo_rd=0 (stall, no timeout).
REQ-019 LAT: SHALL capture stream_data into an 8-bit byte register and go to TX; fifo_rd=0.
REQ-020 TX: when uart_ready=1, SHALL assert uart_send with uart_data=byte register; if cnt==PAYLOAD_BYTES-1, go to DONE, else cnt<=cnt+1 and go to RD; otherwise hold.
REQ-021 cnt SHALL be 4 bits wide and SHALL never wrap within a packet.
REQ-022 DONE: SHALL assert packet_sent for one cycle and go to IDLE.
REQ-023 uart_send SHALL only ever be asserted in a cycle where uart_ready=1, and SHALL be asserted at most once per accepted byte.
REQ-024 Packet length SHALL be exactly 1+PAYLOAD_BYTES uart_send pulses; fifo_rd pulses per packet SHALL equal PAYLOAD_BYTES.
REQ-025 Abort: if select_ready=0 in HDR, RD, LAT or TX, SHALL return to IDLE next cycle without pulsing packet_sent; a byte strobed in that same cycle is still sent.
REQ-026 In IDLE, a select_ready that is already high in the cycle after DONE SHALL start a new packet (back-to-back, one IDLE cycle minimum).
REQ-027 uart_data SHALL hold its last value when uart_send=0.
REQ-028 Changes to mux_select after the IDLE latch SHALL be ignored until the next IDLE.

Reset
REQ-029 reset=1 SHALL force state IDLE and sel=0, cnt=0, byte register=0 on the next rising edge, overriding all other inputs, including mid-packet.
REQ-030 Outputs SHALL be 0 during reset: fifo_rd=8'h00, uart_data=8'h00, uart_send=0, packet_sent=0, ready_to_send=0 (ready_to_send resumes per REQ-015 after release).

Verification
REQ-031 Basic: PAYLOAD_BYTES=4, mux_select=3, select_ready=1, uart_ready=1, FIFO 11,22,33,44 -> uart bytes A3,11,22,33,44; fifo_rd=8'h08 four times; packet_sent once; 14 cycles IDLE-to-IDLE.
REQ-032 Backpressure: uart_ready low for 5 cycles in TX -> uart_send held 0, uart_data stable, byte sent on the first uart_ready=1 cycle, no duplicate.
REQ-033 Underflow: stream_empty=1 for 10 cycles before byte 2 -> fifo_rd=0 throughout the stall, then a single fifo_rd[sel] pulse; byte order preserved.
REQ-034 Abort/reset: select_ready drops after byte 1 -> IDLE, no packet_sent; separately, reset mid-TX -> all outputs 0 next cycle and a clean next packet.
REQ-035 Back-to-back: stream 7 then stream 0 with select_ready continuous -> headers A7 then A0, two packet_sent pulses, stream 0 latched despite mux_select changing during packet 1.

Source files
------------

// File: rtl/packet_sender_ece496_if.sv
// Stream-switch / FIFO / UART side signals of the packet sender.
// master is the sender's view; slave is the surrounding switch, FIFOs and UART.
interface packet_sender_ece496_if;
  logic [2:0] mux_select;
  logic       select_ready;
  logic [7:0] stream_data;
  logic       stream_empty;
  logic       uart_ready;
  logic [7:0] fifo_rd;
  logic [7:0] uart_data;
  logic       uart_send;
  logic       ready_to_send;
  logic       packet_sent;

  modport master (
    input  mux_select, select_ready, stream_data, stream_empty, uart_ready,
    output fifo_rd, uart_data, uart_send, ready_to_send, packet_sent
  );

  modport slave (
    output mux_select, select_ready, stream_data, stream_empty, uart_ready,
    input  fifo_rd, uart_data, uart_send, ready_to_send, packet_sent
  );
endinterface

// File: rtl/packet_sender_ece496.sv
// Sends one header byte {A,0,sel} then PAYLOAD_BYTES bytes pulled from the
// granted stream FIFO to a byte-wide UART; strobes are combinational on uart_ready.
module packet_sender_ece496 #(
  parameter int PAYLOAD_BYTES = 4
) (
  input logic                    clock,
  input logic                    reset,
  packet_sender_ece496_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, RD, LAT, TX, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(PAYLOAD_BYTES - 1);

  state_t     state, state_nxt;
  logic [2:0] sel, sel_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic [7:0] last_data;
  logic [7:0] rd, data;
  logic       send, rts, psent;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      byte_q    <= '0;
      last_data <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      byte_q    <= byte_nxt;
      last_data <= data;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    byte_nxt  = byte_q;
    rd        = '0;
    send      = 1'b0;
    data      = last_data;
    rts       = 1'b0;
    psent     = 1'b0;
    case (state)
      IDLE: begin
        rts = bus.uart_ready;
        if (bus.select_ready) begin
          sel_nxt   = bus.mux_select;
          cnt_nxt   = '0;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (bus.uart_ready) begin
          send      = 1'b1;
          data      = {4'hA, 1'b0, sel};
          state_nxt = RD;
        end
      end
      RD: begin
        if (!bus.stream_empty) begin
          rd        = 8'(1) << sel;
          state_nxt = LAT;
        end
      end
      LAT: begin
        // FIFO read data arrives one cycle after the strobe
        byte_nxt  = bus.stream_data;
        state_nxt = TX;
      end
      TX: begin
        if (bus.uart_ready) begin
          send = 1'b1;
          data = byte_q;
          if (cnt == LAST_CNT) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt + 4'd1;
            state_nxt = RD;
          end
        end
      end
      DONE: begin
        psent     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Losing the grant abandons the packet; any strobe issued this cycle still goes out.
    if (!bus.select_ready && (state == HDR || state == RD || state == LAT || state == TX))
      state_nxt = IDLE;
  end

  assign bus.fifo_rd       = reset ? 8'h00 : rd;
  assign bus.uart_data     = reset ? 8'h00 : data;
  assign bus.uart_send     = reset ? 1'b0  : send;
  assign bus.ready_to_send = reset ? 1'b0  : rts;
  assign bus.packet_sent   = reset ? 1'b0  : psent;
endmodule

// File: tb/tb_packet_sender_ece496.sv
// Directed per-cycle vectors for packet_sender_ece496 (PAYLOAD_BYTES=4):
// inputs driven after the falling edge, outputs checked before the rising edge.
module tb_packet_sender_ece496;
  logic clock;
  logic reset;
  packet_sender_ece496_if bus ();

  packet_sender_ece496 #(.PAYLOAD_BYTES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       sr;
    logic [2:0] ms;
    logic       emp;
    logic [7:0] sd;
    logic       ur;
    logic [7:0] e_rd;
    logic [7:0] e_data;
    logic       e_send;
    logic       e_rts;
    logic       e_ps;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic sr, logic [2:0] ms, logic emp, logic [7:0] sd,
                              logic ur, logic [7:0] e_rd, logic [7:0] e_data, logic e_send,
                              logic e_rts, logic e_ps, string name);
    vec_t v;
    v.rst = rst; v.sr = sr; v.ms = ms; v.emp = emp; v.sd = sd; v.ur = ur;
    v.e_rd = e_rd; v.e_data = e_data; v.e_send = e_send; v.e_rts = e_rts; v.e_ps = e_ps;
    v.name = name;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset            = v.rst;
    bus.select_ready = v.sr;
    bus.mux_select   = v.ms;
    bus.stream_empty = v.emp;
    bus.stream_data  = v.sd;
    bus.uart_ready   = v.ur;
    #1;
    n_vec++;
    if ({bus.fifo_rd, bus.uart_data, bus.uart_send, bus.ready_to_send, bus.packet_sent} !==
        {v.e_rd, v.e_data, v.e_send, v.e_rts, v.e_ps}) begin
      n_bad++;
      $display("FAIL %s @%0t: got rd=%h data=%h send=%b rts=%b sent=%b, want rd=%h data=%h send=%b rts=%b sent=%b",
               v.name, $time, bus.fifo_rd, bus.uart_data, bus.uart_send, bus.ready_to_send,
               bus.packet_sent, v.e_rd, v.e_data, v.e_send, v.e_rts, v.e_ps);
    end
  endtask

  task automatic step(input logic rst, input logic sr, input logic [2:0] ms, input logic emp,
                      input logic [7:0] sd, input logic ur, input logic [7:0] e_rd,
                      input logic [7:0] e_data, input logic e_send, input logic e_rts,
                      input logic e_ps, input string name);
    apply(mk(rst, sr, ms, emp, sd, ur, e_rd, e_data, e_send, e_rts, e_ps, name));
  endtask

  // One payload byte with grant held and UART ready: RD strobe, LAT capture, TX send.
  // Junk 8'hEE on stream_data outside LAT catches a capture on the wrong cycle.
  task automatic do_byte(input logic [2:0] ms, input logic [7:0] e_rd, input logic [7:0] prev,
                         input logic [7:0] b);
    step(0, 1, ms, 0, 8'hEE, 1, e_rd,  prev, 0, 0, 0, "rd");
    step(0, 1, ms, 0, b,     1, 8'h00, prev, 0, 0, 0, "lat");
    step(0, 1, ms, 0, 8'hEE, 1, 8'h00, b,    1, 0, 0, "tx");
  endtask

  initial begin
    logic [7:0] basic_bytes[4];
    logic [7:0] prev;
    basic_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1;
    bus.select_ready = 1'b0; bus.mux_select = 3'd0; bus.stream_empty = 1'b1;
    bus.stream_data = 8'h00; bus.uart_ready = 1'b1;

    // Reset then the basic stream-3 packet, A3 11 22 33 44.
    tbl.push_back(mk(1, 0, 3'd0, 1, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, "reset"));
    tbl.push_back(mk(1, 1, 3'd5, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, "reset_hold"));
    tbl.push_back(mk(0, 0, 3'd0, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0, "idle"));
    tbl.push_back(mk(0, 0, 3'd0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, "idle_uart_busy"));
    tbl.push_back(mk(0, 1, 3'd3, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0, "idle_latch"));
    tbl.push_back(mk(0, 1, 3'd3, 0, 8'h00, 1, 8'h00, 8'hA3, 1, 0, 0, "hdr"));
    prev = 8'hA3;
    foreach (basic_bytes[i]) begin
      tbl.push_back(mk(0, 1, 3'd3, 0, 8'hEE, 1, 8'h08, prev, 0, 0, 0, "basic_rd"));
      tbl.push_back(mk(0, 1, 3'd3, 0, basic_bytes[i], 1, 8'h00, prev, 0, 0, 0, "basic_lat"));
      tbl.push_back(mk(0, 1, 3'd3, 0, 8'hEE, 1, 8'h00, basic_bytes[i], 1, 0, 0, "basic_tx"));
      prev = basic_bytes[i];
    end
    tbl.push_back(mk(0, 0, 3'd3, 0, 8'hEE, 1, 8'h00, 8'h44, 0, 0, 1, "basic_done"));
    tbl.push_back(mk(0, 0, 3'd3, 0, 8'hEE, 1, 8'h00, 8'h44, 0, 1, 0, "basic_idle"));
    tbl.push_back(mk(0, 0, 3'd3, 0, 8'hEE, 1, 8'h00, 8'h44, 0, 1, 0, "basic_no_repeat"));

    foreach (tbl[i]) apply(tbl[i]);

    // Backpressure on byte 1, then a 10-cycle underflow before byte 2 (stream 1).
    step(0, 1, 3'd1, 1, 8'hEE, 1, 8'h00, 8'h44, 0, 1, 0, "bp_idle");
    step(0, 1, 3'd1, 1, 8'hEE, 1, 8'h00, 8'hA1, 1, 0, 0, "bp_hdr");
    step(0, 1, 3'd1, 0, 8'hEE, 1, 8'h02, 8'hA1, 0, 0, 0, "bp_rd");
    step(0, 1, 3'd1, 0, 8'h55, 1, 8'h00, 8'hA1, 0, 0, 0, "bp_lat");
    for (int i = 0; i < 5; i++)
      step(0, 1, 3'd1, 0, 8'hEE, 0, 8'h00, 8'hA1, 0, 0, 0, "bp_hold");
    step(0, 1, 3'd1, 0, 8'hEE, 1, 8'h00, 8'h55, 1, 0, 0, "bp_send");
    for (int i = 0; i < 10; i++)
      step(0, 1, 3'd1, 1, 8'hEE, 1, 8'h00, 8'h55, 0, 0, 0, "uf_stall");
    do_byte(3'd1, 8'h02, 8'h55, 8'h66);
    do_byte(3'd1, 8'h02, 8'h66, 8'h77);
    do_byte(3'd1, 8'h02, 8'h77, 8'h88);
    step(0, 0, 3'd1, 1, 8'hEE, 1, 8'h00, 8'h88, 0, 0, 1, "bp_done");
    step(0, 0, 3'd1, 1, 8'hEE, 1, 8'h00, 8'h88, 0, 1, 0, "bp_idle_after");

    // Grant dropped after byte 1: back to IDLE, no packet_sent.
    step(0, 1, 3'd2, 1, 8'hEE, 1, 8'h00, 8'h88, 0, 1, 0, "ab_idle");
    step(0, 1, 3'd2, 1, 8'hEE, 1, 8'h00, 8'hA2, 1, 0, 0, "ab_hdr");
    do_byte(3'd2, 8'h04, 8'hA2, 8'h99);
    step(0, 0, 3'd2, 1, 8'hEE, 1, 8'h00, 8'h99, 0, 0, 0, "ab_drop");
    step(0, 0, 3'd2, 1, 8'hEE, 1, 8'h00, 8'h99, 0, 1, 0, "ab_idle1");
    step(0, 0, 3'd2, 1, 8'hEE, 1, 8'h00, 8'h99, 0, 1, 0, "ab_idle2");

    // Grant dropped in TX with UART ready: that byte still goes out.
    step(0, 1, 3'd4, 1, 8'hEE, 1, 8'h00, 8'h99, 0, 1, 0, "abtx_idle");
    step(0, 1, 3'd4, 1, 8'hEE, 1, 8'h00, 8'hA4, 1, 0, 0, "abtx_hdr");
    step(0, 1, 3'd4, 0, 8'hEE, 1, 8'h10, 8'hA4, 0, 0, 0, "abtx_rd");
    step(0, 1, 3'd4, 0, 8'h5A, 1, 8'h00, 8'hA4, 0, 0, 0, "abtx_lat");
    step(0, 0, 3'd4, 0, 8'hEE, 1, 8'h00, 8'h5A, 1, 0, 0, "abtx_tx");
    step(0, 0, 3'd4, 0, 8'hEE, 1, 8'h00, 8'h5A, 0, 1, 0, "abtx_idle_after");

    // Reset asserted in TX with UART ready: outputs forced low, registers cleared.
    step(0, 1, 3'd6, 1, 8'hEE, 1, 8'h00, 8'h5A, 0, 1, 0, "rst_idle");
    step(0, 1, 3'd6, 1, 8'hEE, 1, 8'h00, 8'hA6, 1, 0, 0, "rst_hdr");
    step(0, 1, 3'd6, 0, 8'hEE, 1, 8'h40, 8'hA6, 0, 0, 0, "rst_rd");
    step(0, 1, 3'd6, 0, 8'hC3, 1, 8'h00, 8'hA6, 0, 0, 0, "rst_lat");
    step(1, 1, 3'd6, 0, 8'hEE, 1, 8'h00, 8'h00, 0, 0, 0, "rst_in_tx");
    step(0, 0, 3'd6, 0, 8'hEE, 1, 8'h00, 8'h00, 0, 1, 0, "rst_after");

    // Back-to-back: stream 7 then stream 0; mux_select moves to 0 right after the latch.
    step(0, 1, 3'd7, 1, 8'hEE, 1, 8'h00, 8'h00, 0, 1, 0, "b2b_idle1");
    step(0, 1, 3'd0, 1, 8'hEE, 1, 8'h00, 8'hA7, 1, 0, 0, "b2b_hdr1");
    do_byte(3'd0, 8'h80, 8'hA7, 8'h01);
    do_byte(3'd0, 8'h80, 8'h01, 8'h02);
    do_byte(3'd0, 8'h80, 8'h02, 8'h03);
    do_byte(3'd0, 8'h80, 8'h03, 8'h04);
    step(0, 1, 3'd0, 1, 8'hEE, 1, 8'h00, 8'h04, 0, 0, 1, "b2b_done1");
    step(0, 1, 3'd0, 1, 8'hEE, 1, 8'h00, 8'h04, 0, 1, 0, "b2b_idle2");
    step(0, 1, 3'd0, 1, 8'hEE, 1, 8'h00, 8'hA0, 1, 0, 0, "b2b_hdr2");
    do_byte(3'd0, 8'h01, 8'hA0, 8'h10);
    do_byte(3'd0, 8'h01, 8'h10, 8'h20);
    do_byte(3'd0, 8'h01, 8'h20, 8'h30);
    do_byte(3'd0, 8'h01, 8'h30, 8'h40);
    step(0, 0, 3'd0, 1, 8'hEE, 1, 8'h00, 8'h40, 0, 0, 1, "b2b_done2");
    step(0, 0, 3'd0, 1, 8'hEE, 1, 8'h00, 8'h40, 0, 1, 0, "b2b_idle3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
